slide_sequencer: RTL and testbench
==================================

SLIDE_SEQUENCER -- requirements
Module: slide_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: random source width; rnd_in and the rect_* outputs are WIDTH+1 bits.
REQ-002 SHALL have parameter LIMIT, default 255: maximum screen coordinate; x+w and y+h never exceed LIMIT.
REQ-003 SHALL have parameter MIN_SIZE, default 8: minimum rectangle width/height.
REQ-004 SHALL have parameter SAMPLE_GAP, default 3, legal range >=1: clocks between successive rnd_in captures.
REQ-005 SHALL have parameter SLIDE_FRAMES, default 60, legal range >=1: frame_tick pulses between slide acceptance and the next sampling.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port frame_tick  input  1  one-clock pulse per video frame.
REQ-009 SHALL have port rnd_in  input  WIDTH+1  free-running up-counter value used as the random source.
REQ-010 SHALL have port desc_ready  input  1  consumer accepts the descriptor.
REQ-011 SHALL have port desc_valid  output  1  descriptor available.
REQ-012 SHALL have ports rect_x, rect_y, rect_w, rect_h  output  WIDTH+1 each  clamped rectangle descriptor.
REQ-013 SHALL have port slide_idx  output  8  count of accepted slides, wrapping 255->0.
REQ-014 SHALL have port beep_en  output  1  tone enable (see Configuration).

Function
REQ-015 SHALL implement an FSM with states IDLE, SAMP, CLAMP, PRESENT and WAIT.
REQ-016 SHALL move IDLE->SAMP unconditionally on the next clock.
REQ-017 SHALL, in SAMP, capture rnd_in into x, y, w, h in that order at SAMP-entry cycle t0, t0+SAMPLE_GAP, t0+2*SAMPLE_GAP and t0+3*SAMPLE_GAP.
REQ-018 SHALL go SAMP->CLAMP on the cycle after the h capture, and CLAMP->PRESENT after one cycle.
REQ-019 SHALL assert desc_valid exactly 3*SAMPLE_GAP+2 cycles after SAMP entry.
REQ-020 SHALL clamp in CLAMP: w=max(w,MIN_SIZE); if x+w>LIMIT then w=LIMIT-x; if the result is <MIN_SIZE then x=LIMIT-MIN_SIZE and w=MIN_SIZE. y/h SHALL be clamped identically.
REQ-021 SHALL compute the x+w and y+h sums WIDTH+2 bits wide, with no overflow.
REQ-022 SHALL, in PRESENT, hold desc_valid high and all rect_* stable until desc_ready is high; the handshake completes in any cycle with desc_valid&&desc_ready, including the first valid cycle.
REQ-023 SHALL, on handshake: drop desc_valid next cycle, increment slide_idx (mod 256), enter WAIT and clear the frame counter.
REQ-024 SHALL, in WAIT, count frame_tick pulses and go WAIT->SAMP on the clock after the SLIDE_FRAMES-th pulse; a frame_tick in the handshake cycle is not counted.
REQ-025 SHALL ignore frame_tick outside WAIT.
REQ-026 SHALL keep rect_* holding the last accepted descriptor while not in PRESENT; only the PRESENT values are meaningful.

Reset
REQ-027 SHALL, on clock with rst==0 and in any state (mid-sample or mid-handshake included), enter IDLE and clear desc_valid, rect_*, slide_idx, beep_en, the gap counter and the frame counter to 0.
REQ-028 SHALL treat an in-flight descriptor lost to reset as not accepted; slide_idx does not increment.

Configuration
REQ-029 SHALL, when macro SLIDE_SEQUENCER_BEEP_EN is defined, drive beep_en high from the cycle after each handshake until the first frame_tick counted in WAIT, inclusive of that frame.
REQ-030 SHALL, when SLIDE_SEQUENCER_BEEP_EN is undefined, keep the beep_en port present but tie it to 0 and remove the beep logic.

Verification
REQ-031 SHALL verify: WIDTH=8, SAMPLE_GAP=3, rst released at cycle 0, desc_ready=1 -> desc_valid first high at cycle 12; slide_idx 0->1 the next cycle.
REQ-032 SHALL verify: samples x=250, y=10, w=20, h=30, LIMIT=255, MIN_SIZE=8 -> rect_x=247, rect_w=8, rect_y=10, rect_h=30.
REQ-033 SHALL verify: desc_ready held 0 for 50 cycles in PRESENT -> desc_valid and rect_* constant; accepted on the first cycle desc_ready=1.
REQ-034 SHALL verify: SLIDE_FRAMES=2, frame_tick pulses at +1, +5 and +9 cycles after handshake -> SAMP entered the clock after the +5 pulse; the +9 pulse is ignored.
REQ-035 SHALL verify: rst=0 asserted after the y capture -> all outputs 0 next cycle; after release the full sequence restarts and slide_idx stays 0 until handshake.
REQ-036 SHALL verify: 256 accepted slides -> slide_idx wraps to 0; with SLIDE_SEQUENCER_BEEP_EN, beep_en is high from handshake+1 through the first counted frame_tick, and is always 0 without the macro.

Source files
------------

// File: rtl/slide_sequencer_if.sv
// Slide sequencer bus: random source and frame pulse in, rectangle descriptor out.
// master = sequencer side, slave = environment/consumer side.
interface slide_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             frame_tick;
  logic [WIDTH:0]   rnd_in;
  logic             desc_ready;
  logic             desc_valid;
  logic [WIDTH:0]   rect_x;
  logic [WIDTH:0]   rect_y;
  logic [WIDTH:0]   rect_w;
  logic [WIDTH:0]   rect_h;
  logic [7:0]       slide_idx;
  logic             beep_en;

  modport master (
    input  frame_tick, rnd_in, desc_ready,
    output desc_valid, rect_x, rect_y, rect_w, rect_h, slide_idx, beep_en
  );

  modport slave (
    output frame_tick, rnd_in, desc_ready,
    input  desc_valid, rect_x, rect_y, rect_w, rect_h, slide_idx, beep_en
  );
endinterface

// File: rtl/slide_sequencer.sv
// Samples a random rectangle, clamps it on screen, presents it with valid/ready, then waits N frames.
// Optional tone enable after each accepted slide when SLIDE_SEQUENCER_BEEP_EN is defined.
module slide_sequencer #(
  parameter int WIDTH        = 8,
  parameter int LIMIT        = 255,
  parameter int MIN_SIZE     = 8,
  parameter int SAMPLE_GAP   = 3,
  parameter int SLIDE_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst,
  slide_sequencer_if.master bus
);

  localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int FW = (SLIDE_FRAMES > 1) ? $clog2(SLIDE_FRAMES) : 1;

  localparam logic [GW-1:0]  GAP_LAST = GW'(SAMPLE_GAP - 1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);
  localparam logic [FW-1:0]  FRM_LAST = FW'(SLIDE_FRAMES - 1);
  localparam logic [FW-1:0]  FRM_ONE  = FW'(1);
  localparam logic [WIDTH:0] MIN_W    = (WIDTH+1)'(MIN_SIZE);
  localparam logic [WIDTH:0] LIM_W    = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0] EDGE_W   = (WIDTH+1)'(LIMIT - MIN_SIZE);
  localparam logic [WIDTH+1:0] LIM_S  = (WIDTH+2)'(LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    SAMP,
    CLAMP,
    PRESENT,
    WAIT
  } state_t;

  typedef struct packed {
    logic [WIDTH:0] pos;
    logic [WIDTH:0] len;
  } axis_t;

  state_t         state;
  state_t         next_state;
  logic           capture;
  logic           handshake;

  logic [GW-1:0]  gap_cnt;
  logic [1:0]     smp_idx;
  logic [FW-1:0]  frame_cnt;
  logic [WIDTH:0] smp_x;
  logic [WIDTH:0] smp_y;
  logic [WIDTH:0] smp_w;
  logic [WIDTH:0] smp_h;

  logic           valid_q;
  logic [WIDTH:0] rect_x_q;
  logic [WIDTH:0] rect_y_q;
  logic [WIDTH:0] rect_w_q;
  logic [WIDTH:0] rect_h_q;
  logic [7:0]     slide_idx_q;

  axis_t          clamp_x;
  axis_t          clamp_y;

  // Positions beyond LIMIT-MIN_SIZE (including those past LIMIT) snap to the last fitting slot.
  function automatic axis_t clamp_axis(input logic [WIDTH:0] pos, input logic [WIDTH:0] len);
    axis_t            res;
    logic [WIDTH:0]   len_min;
    logic [WIDTH+1:0] sum;
    len_min = (len < MIN_W) ? MIN_W : len;
    sum     = {1'b0, pos} + {1'b0, len_min};
    res.pos = pos;
    res.len = len_min;
    if (sum > LIM_S) begin
      if (pos > EDGE_W) begin
        res.pos = EDGE_W;
        res.len = MIN_W;
      end else begin
        res.len = LIM_W - pos;
      end
    end
    return res;
  endfunction

  assign clamp_x = clamp_axis(smp_x, smp_w);
  assign clamp_y = clamp_axis(smp_y, smp_h);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        next_state = SAMP;
      end
      SAMP: begin
        if (gap_cnt == '0) begin
          capture = 1'b1;
          if (smp_idx == 2'd3) begin
            next_state = CLAMP;
          end
        end
      end
      CLAMP: begin
        next_state = PRESENT;
      end
      PRESENT: begin
        if (valid_q && bus.desc_ready) begin
          handshake  = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.frame_tick && (frame_cnt == FRM_LAST)) begin
          next_state = SAMP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt     <= '0;
      smp_idx     <= '0;
      frame_cnt   <= '0;
      smp_x       <= '0;
      smp_y       <= '0;
      smp_w       <= '0;
      smp_h       <= '0;
      valid_q     <= 1'b0;
      rect_x_q    <= '0;
      rect_y_q    <= '0;
      rect_w_q    <= '0;
      rect_h_q    <= '0;
      slide_idx_q <= '0;
    end else begin
      // Gap counter and sample index restart on every SAMP entry.
      if (state == SAMP) begin
        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_ONE;
        if (capture) begin
          case (smp_idx)
            2'd0: smp_x <= bus.rnd_in;
            2'd1: smp_y <= bus.rnd_in;
            2'd2: smp_w <= bus.rnd_in;
            2'd3: smp_h <= bus.rnd_in;
          endcase
          smp_idx <= smp_idx + 2'd1;
        end
      end else begin
        gap_cnt <= '0;
        smp_idx <= '0;
      end

      if (state == CLAMP) begin
        rect_x_q <= clamp_x.pos;
        rect_w_q <= clamp_x.len;
        rect_y_q <= clamp_y.pos;
        rect_h_q <= clamp_y.len;
        valid_q  <= 1'b1;
      end

      if (handshake) begin
        valid_q     <= 1'b0;
        slide_idx_q <= slide_idx_q + 8'd1;
        frame_cnt   <= '0;
      end else if ((state == WAIT) && bus.frame_tick) begin
        frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + FRM_ONE;
      end
    end
  end

  assign bus.desc_valid = valid_q;
  assign bus.rect_x     = rect_x_q;
  assign bus.rect_y     = rect_y_q;
  assign bus.rect_w     = rect_w_q;
  assign bus.rect_h     = rect_h_q;
  assign bus.slide_idx  = slide_idx_q;

`ifdef SLIDE_SEQUENCER_BEEP_EN
  logic beep_q;

  // High from the cycle after acceptance through the first counted frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beep_q <= 1'b0;
    end else if (handshake) begin
      beep_q <= 1'b1;
    end else if ((state == WAIT) && bus.frame_tick) begin
      beep_q <= 1'b0;
    end
  end

  assign bus.beep_en = beep_q;
`else
  assign bus.beep_en = 1'b0;
`endif

endmodule

// File: tb/tb_slide_sequencer.sv
// Scoreboard bench for slide_sequencer: driver pushes expected descriptors, negedge monitor checks.
// Configuration: WIDTH=8, LIMIT=255, MIN_SIZE=8, SAMPLE_GAP=3, SLIDE_FRAMES=2.
module tb_slide_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  slide_sequencer_if #(.WIDTH(8)) bus ();

  slide_sequencer #(
    .WIDTH(8),
    .LIMIT(255),
    .MIN_SIZE(8),
    .SAMPLE_GAP(3),
    .SLIDE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] w;
    logic [8:0] h;
    int         vcyc;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] noise(input int i);
    return 9'((i * 37 + 101) % 512);
  endfunction

  // One clock cycle with the given inputs; returns at posedge+1.
  task automatic cyc_drive(input logic f, input logic [8:0] r, input logic rdy, input logic rs);
    bus.frame_tick = f;
    bus.rnd_in     = r;
    bus.desc_ready = rdy;
    rst            = rs;
    @(posedge clk);
    #1;
  endtask

  // Called at the start of a SAMP-entry cycle; leaves at the next SAMP entry (or in reset if aborted).
  task automatic do_slide(input logic [8:0] x, input logic [8:0] y, input logic [8:0] w, input logic [8:0] h,
                          input logic [8:0] ex, input logic [8:0] ey, input logic [8:0] ew, input logic [8:0] eh,
                          input int stall, input bit tick_hs, input bit tick_samp, input bit abort);
    logic [8:0] v[4];
    int t0;
    t0 = cyc;
    v[0] = x; v[1] = y; v[2] = w; v[3] = h;
    sb.push_back('{ex, ey, ew, eh, t0 + 11});
    for (int i = 0; i < 11; i++)
      cyc_drive(tick_samp && (i == 3), (i % 3 == 0) ? v[i / 3] : noise(i + t0), 1'b1, 1'b1);
    for (int s = 0; s < stall; s++)
      cyc_drive(s == 2, noise(s), 1'b0, 1'b1);
    if (abort) begin
      cyc_drive(1'b0, noise(1), 1'b0, 1'b0);
      cyc_drive(1'b0, noise(2), 1'b0, 1'b0);
    end else begin
      cyc_drive(tick_hs, noise(3), 1'b1, 1'b1);
      cyc_drive(1'b1, noise(4), 1'b1, 1'b1);
      cyc_drive(1'b0, noise(5), 1'b1, 1'b1);
      cyc_drive(1'b0, noise(6), 1'b1, 1'b1);
      cyc_drive(1'b0, noise(7), 1'b1, 1'b1);
      cyc_drive(1'b1, noise(8), 1'b1, 1'b1);
    end
  endtask

  // Single IDLE cycle with reset released; leaves at SAMP entry.
  task automatic release_rst();
    cyc_drive(1'b0, noise(9), 1'b1, 1'b1);
  endtask

  // Monitor: scoreboard pops, stability, slide_idx/beep model, reset clearing.
  exp_t        cur;
  bit          presenting;
  logic        rst_prev;
  bit          hs_prev;
  logic [7:0]  exp_idx;
  logic        exp_beep;
  bit          hs;

  initial begin
    presenting = 0;
    rst_prev   = 1'b0;
    hs_prev    = 0;
    exp_idx    = 8'd0;
    exp_beep   = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_prev) begin
      check("reset_outputs_zero",
            {bus.desc_valid, bus.rect_x, bus.rect_y, bus.rect_w, bus.rect_h, bus.slide_idx, bus.beep_en}, 64'd0);
    end else begin
      check("slide_idx", bus.slide_idx, exp_idx);
      check("beep_en", bus.beep_en, exp_beep);
      if (hs_prev) check("valid_drop_after_hs", bus.desc_valid, 1'b0);
      if (bus.desc_valid === 1'b1) begin
        if (!presenting) begin
          if (sb.size() == 0) begin
            check("unexpected_desc", 1'b1, 1'b0);
          end else begin
            cur = sb.pop_front();
            check("valid_cycle", cyc, cur.vcyc);
            presenting = 1;
          end
        end
        if (presenting)
          check("rect_xywh", {bus.rect_x, bus.rect_y, bus.rect_w, bus.rect_h}, {cur.x, cur.y, cur.w, cur.h});
      end
    end
    hs = rst && (bus.desc_valid === 1'b1) && bus.desc_ready;
    if (hs) begin
      exp_idx    = exp_idx + 8'd1;
      presenting = 0;
    end
`ifdef SLIDE_SEQUENCER_BEEP_EN
    if (hs) exp_beep = 1'b1;
    else if (bus.frame_tick) exp_beep = 1'b0;
`endif
    if (!rst) begin
      exp_idx    = 8'd0;
      exp_beep   = 1'b0;
      presenting = 0;
    end
    rst_prev = rst;
    hs_prev  = hs;
  end

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b0;
    bus.frame_tick = 1'b0;
    bus.rnd_in     = '0;
    bus.desc_ready = 1'b0;
    repeat (3) cyc_drive(1'b0, 9'h0, 1'b1, 1'b0);
    release_rst();

    // Right-edge clamp; valid 12 cycles after release.
    do_slide(9'd250, 9'd10, 9'd20, 9'd30, 9'd247, 9'd10, 9'd8, 9'd30, 0, 0, 0, 0);
    // Min-size grow and bottom truncation; 50-cycle stall with an ignored tick.
    do_slide(9'd3, 9'd100, 9'd2, 9'd255, 9'd3, 9'd100, 9'd8, 9'd155, 50, 0, 0, 0);
    // Exact fit at LIMIT; tick in the handshake cycle must not count.
    do_slide(9'd0, 9'd247, 9'd255, 9'd8, 9'd0, 9'd247, 9'd255, 9'd8, 0, 1, 0, 0);
    // Position past LIMIT and one-short fit; extra tick during sampling ignored.
    do_slide(9'd300, 9'd248, 9'd5, 9'd0, 9'd247, 9'd247, 9'd8, 9'd8, 0, 0, 1, 0);
    // All-ones samples.
    do_slide(9'd511, 9'd511, 9'd511, 9'd511, 9'd247, 9'd247, 9'd8, 9'd8, 0, 0, 0, 0);

    // Reset right after the y capture, then a full restart.
    for (int i = 0; i < 4; i++)
      cyc_drive(1'b0, (i % 3 == 0) ? 9'd77 : noise(i), 1'b1, 1'b1);
    cyc_drive(1'b0, noise(4), 1'b1, 1'b0);
    cyc_drive(1'b0, noise(5), 1'b1, 1'b0);
    release_rst();
    do_slide(9'd16, 9'd32, 9'd64, 9'd128, 9'd16, 9'd32, 9'd64, 9'd128, 0, 0, 0, 0);

    // Reset while a descriptor is stalled in PRESENT: it is lost, not counted.
    do_slide(9'd40, 9'd50, 9'd60, 9'd70, 9'd40, 9'd50, 9'd60, 9'd70, 5, 0, 0, 1);
    release_rst();

    // 256 accepted slides wrap slide_idx back to 0.
    for (int i = 0; i < 256; i++) begin
      logic [8:0] x, y, w, h;
      x = 9'(i % 200);
      y = 9'((i * 7) % 200);
      w = 9'(20 + (i % 30));
      h = 9'(8 + (i % 40));
      do_slide(x, y, w, h, x, y, w, h, 0, 0, 0, 0);
    end
    check("wrap_idx", bus.slide_idx, 8'd0);

    cyc_drive(1'b0, 9'h0, 1'b0, 1'b0);
    cyc_drive(1'b0, 9'h0, 1'b0, 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
